crtc_video_fetch: RTL and testbench

- Downstream consumer of the 6845-class CRTC Wishbone wrapper. Takes the CRTC's MA/RA/DE/HSYNC per character and fetches two video bytes per character from video RAM through a Wishbone read master.
- Serialises the fetched bytes into 4-bit ink indices in CPC-style mode 0/1/2 encoding.
- Output feeds the palette/colour lookup stage.

---
 rtl/crtc_video_fetch.sv | 254 +++++++++++++++++++++++++
 tb/tb_crtc_video_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_video_fetch.sv
// crtc_video_fetch
//   Per-character video fetch and pixel serialiser behind a 6845-class CRTC.
//   At each character boundary the CRTC address is latched. While de_i is
//   high, two bytes are read from video RAM over a Wishbone read master.
//   The bytes fetched for character N are shifted out as 4-bit ink indices
//   during character N+1, using CPC-style mode 0/1/2 pixel packing.
//
// Ports
//   clk_i, rst_ni           system clock, async active-low reset
//   char_stb_i, pix_stb_i   character boundary pulse, pixel enable (16 per char)
//   ma_i, ra_i, de_i        CRTC memory/row address and display enable
//   hsync_i, mode_i         screen mode is sampled on the hsync rising edge
//   mem_adr_o, mem_stb_o    Wishbone read request
//   mem_ack_i, mem_dat_i    Wishbone acknowledge and read data
//   pix_ink_o, pix_de_o     registered pixel ink index and active flag
//   overrun_o, timeout_o    single-cycle error pulses
//
// Fetch FSM
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no read in flight
//   ST_RD0  | strobing byte0 at base, waiting for ack
//   ST_RD1  | strobing byte1 at base|1, waiting for ack

module crtc_video_fetch #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        char_stb_i,
    input  logic        pix_stb_i,
    input  logic [13:0] ma_i,
    input  logic [4:0]  ra_i,
    input  logic        de_i,
    input  logic        hsync_i,
    input  logic [1:0]  mode_i,
    output logic [15:0] mem_adr_o,
    output logic        mem_stb_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_dat_i,
    output logic [3:0]  pix_ink_o,
    output logic        pix_de_o,
    output logic        overrun_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2
    } state_t;

    localparam logic [3:0] TMO_LOAD = 4'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [14:0] base_q, base_d;      // byte address bits [15:1]
    logic [3:0]  tcnt_q, tcnt_d;
    logic [7:0]  byte0_q, byte0_d;
    logic [7:0]  byte1_q, byte1_d;
    logic        valid_q, valid_d;
    logic        discard_q, discard_d;
    logic        de_char_q, de_char_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  pcnt_q, pcnt_d;
    logic        disp_q, disp_d;
    logic [1:0]  mode_q, mode_d;
    logic        hsync_q, hsync_d;
    logic [3:0]  ink_q, ink_d;
    logic        pde_q, pde_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;

    // Effective pixel-path values this cycle: a coincident char_stb_i load
    // is visible to the pixel emitted in the same cycle.
    logic [15:0] cur_shift;
    logic [3:0]  cur_cnt;
    logic        cur_disp;
    logic [7:0]  cur_byte;
    logic [3:0]  ink_calc;
    logic        do_shift;

    // Address bits the CRTC drives but the memory map does not use.
    logic unused_ok;
    assign unused_ok = &{1'b0, ma_i[11:10], ra_i[4:3]};

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        tcnt_d    = tcnt_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        valid_d   = valid_q;
        discard_d = discard_q;
        de_char_d = de_char_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (char_stb_i && de_i) begin
                    state_d   = ST_RD0;
                    base_d    = {ma_i[13:12], ra_i[2:0], ma_i[9:0]};
                    tcnt_d    = TMO_LOAD;
                    discard_d = 1'b0;
                end
            end
            ST_RD0: begin
                if (mem_ack_i) begin
                    byte0_d = mem_dat_i;
                    tcnt_d  = TMO_LOAD;
                    state_d = ST_RD1;
                end else if (tcnt_q == 4'd0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
            end
            ST_RD1: begin
                if (mem_ack_i) begin
                    byte1_d = mem_dat_i;
                    valid_d = ~discard_q;
                    state_d = ST_IDLE;
                end else if (tcnt_q == 4'd0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A boundary during a fetch marks its result stale; valid is also
        // cleared below, which covers a completion in this same cycle.
        if (char_stb_i && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
            discard_d = 1'b1;
        end

        if (char_stb_i) begin
            de_char_d = de_i & (state_q == ST_IDLE);
            valid_d   = 1'b0;
        end
    end

    always_comb begin
        shift_d  = shift_q;
        pcnt_d   = pcnt_q;
        disp_d   = disp_q;
        ink_d    = ink_q;
        pde_d    = pde_q;
        mode_d   = mode_q;
        hsync_d  = hsync_i;
        do_shift = 1'b0;

        if (hsync_i && !hsync_q) begin
            mode_d = mode_i;
        end

        cur_shift = shift_q;
        cur_cnt   = pcnt_q;
        cur_disp  = disp_q;
        if (char_stb_i) begin
            cur_shift = valid_q ? {byte0_q, byte1_q} : 16'h0000;
            cur_cnt   = 4'd0;
            cur_disp  = valid_q & de_char_q;
        end
        cur_byte = cur_shift[15:8];

        case (mode_q)
            2'd2:    ink_calc = {3'b000, cur_byte[7]};
            2'd1:    ink_calc = {2'b00, cur_byte[3], cur_byte[7]};
            default: ink_calc = {cur_byte[1], cur_byte[5], cur_byte[3], cur_byte[7]};
        endcase

        // Shift cadence: every strobe (mode 2), every 2nd (mode 1), every 4th (mode 0/3).
        case (mode_q)
            2'd2:    do_shift = 1'b1;
            2'd1:    do_shift = cur_cnt[0];
            default: do_shift = &cur_cnt[1:0];
        endcase

        shift_d = cur_shift;
        pcnt_d  = cur_cnt;
        disp_d  = cur_disp;

        if (pix_stb_i) begin
            ink_d = cur_disp ? ink_calc : 4'd0;
            pde_d = cur_disp;
            if (cur_cnt == 4'd15) begin
                // Saturated: extra strobes repeat the last pixel.
                shift_d = cur_shift;
            end else begin
                pcnt_d = cur_cnt + 4'd1;
                if (cur_cnt == 4'd7) begin
                    shift_d = {cur_shift[7:0], 8'h00};
                end else if (do_shift) begin
                    // Only the displayed byte shifts; byte1 waits untouched.
                    shift_d = {cur_shift[14:8], 1'b0, cur_shift[7:0]};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            tcnt_q    <= '0;
            byte0_q   <= '0;
            byte1_q   <= '0;
            valid_q   <= 1'b0;
            discard_q <= 1'b0;
            de_char_q <= 1'b0;
            shift_q   <= '0;
            pcnt_q    <= '0;
            disp_q    <= 1'b0;
            mode_q    <= '0;
            hsync_q   <= 1'b0;
            ink_q     <= '0;
            pde_q     <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            tcnt_q    <= tcnt_d;
            byte0_q   <= byte0_d;
            byte1_q   <= byte1_d;
            valid_q   <= valid_d;
            discard_q <= discard_d;
            de_char_q <= de_char_d;
            shift_q   <= shift_d;
            pcnt_q    <= pcnt_d;
            disp_q    <= disp_d;
            mode_q    <= mode_d;
            hsync_q   <= hsync_d;
            ink_q     <= ink_d;
            pde_q     <= pde_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobe decoded straight from the state flop so reset drops it at once.
    assign mem_stb_o = (state_q != ST_IDLE);
    assign mem_adr_o = {base_q, (state_q == ST_RD1)};
    assign pix_ink_o = ink_q;
    assign pix_de_o  = pde_q;
    assign overrun_o = overrun_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_crtc_video_fetch.sv
// Directed bench for crtc_video_fetch: a behavioural video RAM with a
// programmable ack delay, 16-cycle characters with a pixel strobe on every
// cycle, and hand-computed expected pixel streams.

module tb_crtc_video_fetch;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        char_stb_i = 1'b0;
    logic        pix_stb_i = 1'b0;
    logic [13:0] ma_i = '0;
    logic [4:0]  ra_i = '0;
    logic        de_i = 1'b0;
    logic        hsync_i = 1'b0;
    logic [1:0]  mode_i = '0;
    logic [15:0] mem_adr_o;
    logic        mem_stb_o;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_dat_i = '0;
    logic [3:0]  pix_ink_o;
    logic        pix_de_o;
    logic        overrun_o;
    logic        timeout_o;

    crtc_video_fetch #(.ACK_TIMEOUT(15)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .char_stb_i (char_stb_i),
        .pix_stb_i  (pix_stb_i),
        .ma_i       (ma_i),
        .ra_i       (ra_i),
        .de_i       (de_i),
        .hsync_i    (hsync_i),
        .mode_i     (mode_i),
        .mem_adr_o  (mem_adr_o),
        .mem_stb_o  (mem_stb_o),
        .mem_ack_i  (mem_ack_i),
        .mem_dat_i  (mem_dat_i),
        .pix_ink_o  (pix_ink_o),
        .pix_de_o   (pix_de_o),
        .overrun_o  (overrun_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    logic [7:0]  ram [0:65535];
    logic [15:0] adr_log [$];
    int          ack_delay = 1;
    logic        ack_en = 1'b1;
    int          ack_cnt = 0;

    // Memory model: ack asserted after ack_delay strobed cycles, held one cycle.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mem_ack_i = 1'b0;
            ack_cnt   = 0;
        end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            ack_cnt   = 0;
        end else if (mem_stb_o && ack_en) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
                mem_ack_i = 1'b1;
                mem_dat_i = ram[mem_adr_o];
                adr_log.push_back(mem_adr_o);
            end
        end else begin
            ack_cnt = 0;
        end
    end

    logic [3:0] ink_a [16];
    logic       de_a  [16];
    int         stb_cyc, ov_n, to_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_char(input logic de, input logic [13:0] ma, input logic [4:0] ra);
        stb_cyc = 0;
        ov_n    = 0;
        to_n    = 0;
        for (int k = 0; k < 16; k++) begin
            char_stb_i = (k == 0);
            pix_stb_i  = 1'b1;
            if (k == 0) begin
                de_i = de;
                ma_i = ma;
                ra_i = ra;
            end
            @(negedge clk_i);
            ink_a[k] = pix_ink_o;
            de_a[k]  = pix_de_o;
            if (mem_stb_o) stb_cyc++;
            if (overrun_o) ov_n++;
            if (timeout_o) to_n++;
        end
        char_stb_i = 1'b0;
        pix_stb_i  = 1'b0;
    endtask

    // Pixel 0 sits in the most significant nibble / bit of the expectations.
    task automatic chk_disp(input string tag, input logic [63:0] exp_ink, input logic [15:0] exp_de);
        logic [63:0] obs_ink;
        logic [15:0] obs_de;
        for (int k = 0; k < 16; k++) begin
            obs_ink[(15-k)*4 +: 4] = ink_a[k];
            obs_de[15-k]           = de_a[k];
        end
        chk({tag, "_ink"}, obs_ink, exp_ink);
        chk({tag, "_de"}, {48'h0, obs_de}, {48'h0, exp_de});
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode_i  = m;
        hsync_i = 1'b1;
        @(negedge clk_i);
        hsync_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
        ram[16'h0000] = 8'hA5;
        ram[16'h0001] = 8'h0F;
        ram[16'hED78] = 8'h88;
        ram[16'hED79] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_stb", {63'h0, mem_stb_o}, 64'h0);
        chk("rst_adr", {48'h0, mem_adr_o}, 64'h0);
        chk("rst_ink", {60'h0, pix_ink_o}, 64'h0);
        chk("rst_flags", {61'h0, pix_de_o, overrun_o, timeout_o}, 64'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Mode 2 fetch of 0xA5/0x0F from address 0
        set_mode(2'd2);
        ack_delay = 1;
        run_char(1'b1, 14'h0000, 5'd0);
        chk("m2_nacc", adr_log.size(), 64'd2);
        if (adr_log.size() >= 2) begin
            chk("m2_adr0", {48'h0, adr_log[0]}, 64'h0000);
            chk("m2_adr1", {48'h0, adr_log[1]}, 64'h0001);
        end
        adr_log.delete();

        // {ma[13:12]=11, ra[2:0]=101, ma[9:0]=10_1011_1100, 0} = 0xED78
        run_char(1'b1, 14'h3ABC, 5'd5);
        chk_disp("m2_pix", 64'h1010_0101_0000_1111, 16'hFFFF);
        chk("map_nacc", adr_log.size(), 64'd2);
        if (adr_log.size() >= 2) begin
            chk("map_adr0", {48'h0, adr_log[0]}, 64'hED78);
            chk("map_adr1", {48'h0, adr_log[1]}, 64'hED79);
        end
        adr_log.delete();

        // Mode 0 latched by hsync; later mode_i change without hsync ignored
        set_mode(2'd0);
        mode_i = 2'd2;
        run_char(1'b0, 14'h0000, 5'd0);
        chk_disp("m0_pix", 64'h3333_0000_0000_0000, 16'hFFFF);
        chk("border_nostb", stb_cyc, 64'd0);

        // Border display; this character's fetch times out (no ack)
        ack_en = 1'b0;
        run_char(1'b1, 14'h0000, 5'd0);
        chk_disp("border_pix", 64'h0, 16'h0000);
        chk("tmo_stb_cycles", stb_cyc, 64'd15);
        chk("tmo_pulses", to_n, 64'd1);
        ack_en = 1'b1;

        // Timed-out character displays blank; this fetch is too slow (overrun)
        ack_delay = 10;
        run_char(1'b1, 14'h0000, 5'd0);
        chk_disp("tmo_pix", 64'h0, 16'h0000);
        chk("tmo_nopulse", to_n, 64'd0);
        chk("ovr_early", ov_n, 64'd0);

        run_char(1'b1, 14'h0000, 5'd0);
        chk("ovr_pulses", ov_n, 64'd1);
        chk_disp("ovr_pix0", 64'h0, 16'h0000);

        run_char(1'b0, 14'h0000, 5'd0);
        chk_disp("ovr_pix1", 64'h0, 16'h0000);
        chk("ovr_nofetch", stb_cyc, 64'd0);
        chk("ovr_once", ov_n, 64'd0);

        // Reset asserted while strobing byte1
        ack_delay  = 1;
        de_i       = 1'b1;
        ma_i       = 14'h0000;
        ra_i       = 5'd0;
        char_stb_i = 1'b1;
        @(negedge clk_i);
        char_stb_i = 1'b0;
        @(negedge clk_i);
        chk("rd1_stb", {63'h0, mem_stb_o}, 64'h1);
        chk("rd1_adr", {48'h0, mem_adr_o}, 64'h0001);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_stb", {63'h0, mem_stb_o}, 64'h0);
        chk("rst_mid_adr", {48'h0, mem_adr_o}, 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
